sram_controller: RTL and testbench
==================================

# sram_controller

Responder for the MEM stage's data-memory port. Accepts one 32-bit read or write per request from the pipeline, splits it into two 16-bit accesses to an external asynchronous SRAM, and holds the pipeline via `ready` until the access completes. It sits between the MEM stage and the board SRAM. While `ready` is low, the datapath drives its global `freeze`.

## Interface

Parameters:
- `WAIT_CYCLES`, default 2: cycles spent on each 16-bit half-access. Legal values are 2 to 15.
- `BASE_ADDR`, default 32'd1024: byte address mapped to SRAM word 0.

Ports. Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous active-high reset
- `MEM_R_EN`  in  1  read request from the MEM stage
- `MEM_W_EN`  in  1  write request from the MEM stage
- `ALU_Res`  in  32  byte address
- `Val_RM`  in  32  write data
- `Mem_out`  out  32  read data
- `ready`  out  1  access complete, or no access pending
- `SRAM_ADDR`  out  18  SRAM half-word address
- `SRAM_DQ_out`  out  16  SRAM write data
- `SRAM_DQ_oe`  out  1  drive enable for SRAM DQ
- `SRAM_DQ_in`  in  16  SRAM read data
- `SRAM_WE_N`  out  1  SRAM write strobe, active low
- `SRAM_OE_N`  out  1  SRAM output enable, active low

## Operation

**Address mapping**
- `word = (ALU_Res - BASE_ADDR) >> 2`.
- `SRAM_ADDR = {word[16:0], half}`, where `half` is 0 for bits [15:0] and 1 for bits [31:16].
- Upper address bits are ignored, with wrap-around modulo 2^17 words.

**States:** IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. A 4-bit phase counter `cnt` runs within each access state.

**Transitions**
- IDLE:
  - `MEM_W_EN` → WR_LO. Write has priority if both requests are asserted.
  - `MEM_R_EN` only → RD_LO.
  - Otherwise stay in IDLE.
  - `cnt` is cleared on entry to any access state.
- RD_LO / WR_LO: when `cnt == WAIT_CYCLES-1`, go to RD_HI / WR_HI and clear `cnt`. Otherwise increment `cnt`.
- RD_HI / WR_HI: when `cnt == WAIT_CYCLES-1`, go to DONE.
- DONE → IDLE unconditionally.

**`ready` (combinational)**
- 1 in IDLE when neither `MEM_R_EN` nor `MEM_W_EN` is asserted.
- 1 in DONE.
- 0 otherwise.

**Request rules**
- The requester holds `ALU_Res`, `Val_RM` and the enables stable while `ready` is 0.
- Inputs are latched into an internal request register on leaving IDLE. Later input changes do not affect the access in flight.

**Reads**
- `SRAM_OE_N = 0` in RD_LO and RD_HI. `SRAM_DQ_oe = 0`.
- `SRAM_DQ_in` is sampled on the last cycle of RD_LO into `Mem_out[15:0]`.
- `SRAM_DQ_in` is sampled on the last cycle of RD_HI into `Mem_out[31:16]`.
- `Mem_out` holds its value until the next read completes.

**Writes**
- `SRAM_DQ_oe = 1` in WR_LO and WR_HI.
- `SRAM_DQ_out` is `Val_RM[15:0]` in WR_LO and `Val_RM[31:16]` in WR_HI.
- `SRAM_WE_N = 0` while `cnt < WAIT_CYCLES-1`. It is 1 on the last cycle of each phase, so address and data are held while the strobe is high.
- `Mem_out` is unchanged by writes.

**Idle outputs**
- `SRAM_WE_N = 1`, `SRAM_OE_N = 1`, `SRAM_DQ_oe = 0`, `SRAM_ADDR` holds its last value.

## Timing

**Reset values:** state IDLE, `cnt = 0`, `Mem_out = 0`, `SRAM_ADDR = 0`, `SRAM_DQ_out = 0`, `SRAM_DQ_oe = 0`, `SRAM_WE_N = 1`, `SRAM_OE_N = 1`. `ready` is then determined by the inputs.

**Latency**
- Request seen in IDLE at cycle 0 → `ready` is low for cycles 0 .. 2·WAIT_CYCLES.
- `ready` is high at cycle 2·WAIT_CYCLES+1, which is the DONE cycle.
- With the default WAIT_CYCLES = 2, `ready` rises at cycle 5.
- Read data is valid on `Mem_out` in DONE and after.

**Back-to-back:** a new request presented in the cycle after DONE starts from IDLE. There is no idle bubble beyond the IDLE evaluation cycle.

**Reset mid-access:** immediate return to IDLE with reset output values. A partially written word may be left in SRAM. `Mem_out` is cleared.

## Configuration

Macro `SRAM_CTRL_COUNT_EN`.
- **Defined:** adds outputs `rd_count[15:0]` and `wr_count[15:0]`.
  - Each increments by 1 on entry to DONE for a read or a write respectively.
  - Both wrap from 16'hFFFF to 0 and reset to 0.
- **Undefined:** these ports and their counters are absent. All other behaviour is identical.

## Test plan

- **Reset:** assert `rst` for 3 cycles with no request → `SRAM_WE_N = 1`, `SRAM_OE_N = 1`, `SRAM_DQ_oe = 0`, `Mem_out = 0`, `ready = 1`.
- **Write:** `MEM_W_EN = 1`, `ALU_Res = 1032`, `Val_RM = 32'hDEADBEEF`, WAIT = 2 →
  - `SRAM_ADDR` 4 carrying 16'hBEEF, then `SRAM_ADDR` 5 carrying 16'hDEAD.
  - `SRAM_WE_N` low one cycle per half.
  - `ready` high at cycle 5.
- **Read:** SRAM model returns the stored data; `MEM_R_EN = 1`, `ALU_Res = 1032` → `Mem_out = 32'hDEADBEEF` and `ready` high at cycle 5. `SRAM_OE_N` is low for cycles 1–4.
- **Both requests:** `MEM_R_EN` and `MEM_W_EN` both asserted → write sequence executes and `Mem_out` is unchanged.
- **Reset mid-access:** `rst` asserted in RD_HI → next cycle state IDLE, `SRAM_OE_N = 1`, `Mem_out = 0`. A following read completes normally.
- **Counters and wrap:** with `SRAM_CTRL_COUNT_EN` defined, 3 writes then 2 reads → `wr_count = 3`, `rd_count = 2`. `ALU_Res = BASE_ADDR + 2^19` maps to `SRAM_ADDR` 0/1.

Source files
------------

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two 16-bit asynchronous SRAM accesses and stalls via ready.
// Optional access counters are enabled by defining SRAM_CTRL_COUNT_EN.
module sram_controller #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SRAM_CTRL_COUNT_EN
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
`endif
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] Val_RM,
  output logic [31:0] Mem_out,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] offs;
  logic [16:0] req_word;
  logic [15:0] req_hi;
  logic        unused_offs;

  // Bits above the 17-bit word index are dropped, giving wrap-around.
  assign offs        = ALU_Res - BASE_ADDR;
  assign unused_offs = ^{offs[31:19], offs[1:0]};

  assign ready = ((state == IDLE) && !MEM_R_EN && !MEM_W_EN) || (state == DONE);

  // Request capture: only the upper write half is needed after the first phase.
  always_ff @(posedge clk) begin
    if (state == IDLE && (MEM_R_EN || MEM_W_EN)) begin
      req_word <= offs[18:2];
      req_hi   <= Val_RM[31:16];
    end
  end

  // Sequencer: SRAM pins are registered and updated on each state transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      Mem_out     <= 32'd0;
      SRAM_ADDR   <= 18'd0;
      SRAM_DQ_out <= 16'd0;
      SRAM_DQ_oe  <= 1'b0;
      SRAM_WE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
`ifdef SRAM_CTRL_COUNT_EN
      rd_count    <= 16'd0;
      wr_count    <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (MEM_W_EN) begin
            state       <= WR_LO;
            SRAM_ADDR   <= {offs[18:2], 1'b0};
            SRAM_DQ_out <= Val_RM[15:0];
            SRAM_DQ_oe  <= 1'b1;
            SRAM_WE_N   <= 1'b0;
          end else if (MEM_R_EN) begin
            state     <= RD_LO;
            SRAM_ADDR <= {offs[18:2], 1'b0};
            SRAM_OE_N <= 1'b0;
          end
        end
        RD_LO: begin
          if (cnt == LAST) begin
            Mem_out[15:0] <= SRAM_DQ_in;
            state         <= RD_HI;
            cnt           <= 4'd0;
            SRAM_ADDR     <= {req_word, 1'b1};
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RD_HI: begin
          if (cnt == LAST) begin
            Mem_out[31:16] <= SRAM_DQ_in;
            state          <= DONE;
            SRAM_OE_N      <= 1'b1;
`ifdef SRAM_CTRL_COUNT_EN
            rd_count       <= rd_count + 16'd1;
`endif
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_LO: begin
          if (cnt == LAST) begin
            state       <= WR_HI;
            cnt         <= 4'd0;
            SRAM_ADDR   <= {req_word, 1'b1};
            SRAM_DQ_out <= req_hi;
            SRAM_WE_N   <= 1'b0;
          end else begin
            cnt       <= cnt + 4'd1;
            // Strobe rises for the final cycle so address/data outlast it.
            SRAM_WE_N <= (cnt + 4'd1 == LAST);
          end
        end
        WR_HI: begin
          if (cnt == LAST) begin
            state      <= DONE;
            SRAM_WE_N  <= 1'b1;
            SRAM_DQ_oe <= 1'b0;
`ifdef SRAM_CTRL_COUNT_EN
            wr_count   <= wr_count + 16'd1;
`endif
          end else begin
            cnt       <= cnt + 4'd1;
            SRAM_WE_N <= (cnt + 4'd1 == LAST);
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural asynchronous SRAM model.
// Counter checks are active when SRAM_CTRL_COUNT_EN is defined.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_Res, Val_RM, Mem_out;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
  logic        SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N;
`ifdef SRAM_CTRL_COUNT_EN
  logic [15:0] rd_count, wr_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:1023];
  logic [17:0] wa_q[$];
  logic [15:0] wd_q[$];

  always #5 clk = ~clk;

  sram_controller dut (
    .clk(clk),
    .rst(rst),
`ifdef SRAM_CTRL_COUNT_EN
    .rd_count(rd_count),
    .wr_count(wr_count),
`endif
    .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res),
    .Val_RM(Val_RM),
    .Mem_out(Mem_out),
    .ready(ready),
    .SRAM_ADDR(SRAM_ADDR),
    .SRAM_DQ_out(SRAM_DQ_out),
    .SRAM_DQ_oe(SRAM_DQ_oe),
    .SRAM_DQ_in(SRAM_DQ_in),
    .SRAM_WE_N(SRAM_WE_N),
    .SRAM_OE_N(SRAM_OE_N)
  );

  // SRAM latches on the rising edge of the write strobe.
  assign SRAM_DQ_in = SRAM_OE_N ? 16'h0000 : mem[SRAM_ADDR[9:0]];

  always @(posedge SRAM_WE_N) begin
    if (SRAM_DQ_oe === 1'b1) begin
      mem[SRAM_ADDR[9:0]] = SRAM_DQ_out;
      wa_q.push_back(SRAM_ADDR);
      wd_q.push_back(SRAM_DQ_out);
    end
  end

  task automatic run_access(input logic w, input logic r, input logic [31:0] addr,
                            input logic [31:0] data, output int rdy_cyc,
                            output logic [7:0] oe_mask, output int we_low);
    rdy_cyc = -1;
    oe_mask = 8'h00;
    we_low  = 0;
    @(posedge clk);
    #1;
    MEM_W_EN = w;
    MEM_R_EN = r;
    ALU_Res  = addr;
    Val_RM   = data;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k < 8) oe_mask[k] = !SRAM_OE_N;
      if (SRAM_WE_N === 1'b0) we_low++;
      if (ready === 1'b1) begin
        rdy_cyc = k;
        break;
      end
    end
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    ALU_Res = 32'd0;
    Val_RM = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (SRAM_WE_N !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b want 1", SRAM_WE_N); end
    n_checks++; if (SRAM_OE_N !== 1'b1) begin n_fail++; $display("FAIL reset_oe_n: got %b want 1", SRAM_OE_N); end
    n_checks++; if (SRAM_DQ_oe !== 1'b0) begin n_fail++; $display("FAIL reset_dq_oe: got %b want 0", SRAM_DQ_oe); end
    n_checks++; if (Mem_out !== 32'd0) begin n_fail++; $display("FAIL reset_mem_out: got %h want 0", Mem_out); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_checks++; if (SRAM_ADDR !== 18'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", SRAM_ADDR); end
  endtask

  task automatic test_write();
    int rc, wl;
    logic [7:0] om;
    wa_q.delete(); wd_q.delete();
    run_access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, rc, om, wl);
    go_idle();
    n_checks++; if (rc !== 5) begin n_fail++; $display("FAIL write_ready_cycle: got %0d want 5", rc); end
    n_checks++; if (wl !== 2) begin n_fail++; $display("FAIL write_we_low_cycles: got %0d want 2", wl); end
    n_checks++; if (om !== 8'h00) begin n_fail++; $display("FAIL write_oe_mask: got %b want 0", om); end
    n_checks++; if (wa_q.size() !== 2) begin n_fail++; $display("FAIL write_strobes: got %0d want 2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      n_checks++; if (wa_q[0] !== 18'd4 || wd_q[0] !== 16'hBEEF) begin n_fail++; $display("FAIL write_lo: got %0d/%h want 4/beef", wa_q[0], wd_q[0]); end
      n_checks++; if (wa_q[1] !== 18'd5 || wd_q[1] !== 16'hDEAD) begin n_fail++; $display("FAIL write_hi: got %0d/%h want 5/dead", wa_q[1], wd_q[1]); end
    end
    n_checks++; if (Mem_out !== 32'd0) begin n_fail++; $display("FAIL write_mem_out: got %h want 0", Mem_out); end
    @(negedge clk);
    n_checks++; if (ready !== 1'b1 || SRAM_DQ_oe !== 1'b0) begin n_fail++; $display("FAIL write_idle: got ready %b oe %b want 1 0", ready, SRAM_DQ_oe); end
  endtask

  task automatic test_read();
    int rc, wl;
    logic [7:0] om;
    run_access(1'b0, 1'b1, 32'd1032, 32'h0, rc, om, wl);
    n_checks++; if (rc !== 5) begin n_fail++; $display("FAIL read_ready_cycle: got %0d want 5", rc); end
    n_checks++; if (Mem_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: got %h want deadbeef", Mem_out); end
    n_checks++; if (om !== 8'b0001_1110) begin n_fail++; $display("FAIL read_oe_mask: got %b want 00011110", om); end
    n_checks++; if (wl !== 0) begin n_fail++; $display("FAIL read_we_low: got %0d want 0", wl); end
    go_idle();
    @(negedge clk);
    n_checks++; if (Mem_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_hold: got %h want deadbeef", Mem_out); end
  endtask

  task automatic test_both();
    int rc, wl;
    logic [7:0] om;
    wa_q.delete(); wd_q.delete();
    run_access(1'b1, 1'b1, 32'd1036, 32'h12345678, rc, om, wl);
    go_idle();
    n_checks++; if (rc !== 5 || om !== 8'h00 || wl !== 2) begin n_fail++; $display("FAIL both_seq: got rc %0d oe %b we %0d want 5 0 2", rc, om, wl); end
    n_checks++; if (Mem_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL both_mem_out: got %h want deadbeef", Mem_out); end
    n_checks++; if (wa_q.size() !== 2) begin n_fail++; $display("FAIL both_strobes: got %0d want 2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      n_checks++; if (wa_q[1] !== 18'd7 || wd_q[1] !== 16'h1234) begin n_fail++; $display("FAIL both_hi: got %0d/%h want 7/1234", wa_q[1], wd_q[1]); end
    end
    run_access(1'b0, 1'b1, 32'd1036, 32'h0, rc, om, wl);
    go_idle();
    n_checks++; if (Mem_out !== 32'h12345678) begin n_fail++; $display("FAIL both_readback: got %h want 12345678", Mem_out); end
  endtask

  task automatic test_reset_mid();
    int rc, wl;
    logic [7:0] om;
    @(posedge clk);
    #1;
    MEM_R_EN = 1'b1;
    ALU_Res  = 32'd1032;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++; if (SRAM_OE_N !== 1'b1) begin n_fail++; $display("FAIL mid_oe_n: got %b want 1", SRAM_OE_N); end
    n_checks++; if (Mem_out !== 32'd0) begin n_fail++; $display("FAIL mid_mem_out: got %h want 0", Mem_out); end
    n_checks++; if (ready !== 1'b0 || SRAM_ADDR !== 18'd0) begin n_fail++; $display("FAIL mid_idle_req: got ready %b addr %0d want 0 0", ready, SRAM_ADDR); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    MEM_R_EN = 1'b0;
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", ready); end
    run_access(1'b0, 1'b1, 32'd1032, 32'h0, rc, om, wl);
    go_idle();
    n_checks++; if (rc !== 5 || Mem_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mid_followup: got %0d/%h want 5/deadbeef", rc, Mem_out); end
  endtask

  task automatic test_wrap();
    int rc, wl;
    logic [7:0] om;
    wa_q.delete(); wd_q.delete();
    run_access(1'b1, 1'b0, 32'd1024 + 32'h0008_0000, 32'hCAFEF00D, rc, om, wl);
    go_idle();
    n_checks++; if (wa_q.size() !== 2) begin n_fail++; $display("FAIL wrap_strobes: got %0d want 2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      n_checks++; if (wa_q[0] !== 18'd0 || wa_q[1] !== 18'd1) begin n_fail++; $display("FAIL wrap_addr: got %0d,%0d want 0,1", wa_q[0], wa_q[1]); end
    end
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, rc, om, wl);
    go_idle();
    n_checks++; if (Mem_out !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wrap_read: got %h want cafef00d", Mem_out); end
  endtask

  task automatic test_back_to_back();
    int rc, wl;
    logic [7:0] om;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    run_access(1'b1, 1'b0, 32'd1040, 32'hAAAA1111, rc, om, wl);
    n_checks++; if (rc !== 5) begin n_fail++; $display("FAIL b2b_w0: got %0d want 5", rc); end
    run_access(1'b1, 1'b0, 32'd1044, 32'hBBBB2222, rc, om, wl);
    n_checks++; if (rc !== 5) begin n_fail++; $display("FAIL b2b_w1: got %0d want 5", rc); end
    run_access(1'b1, 1'b0, 32'd1048, 32'hCCCC3333, rc, om, wl);
    n_checks++; if (rc !== 5) begin n_fail++; $display("FAIL b2b_w2: got %0d want 5", rc); end
    run_access(1'b0, 1'b1, 32'd1040, 32'h0, rc, om, wl);
    n_checks++; if (rc !== 5 || Mem_out !== 32'hAAAA1111) begin n_fail++; $display("FAIL b2b_r0: got %0d/%h want 5/aaaa1111", rc, Mem_out); end
    run_access(1'b0, 1'b1, 32'd1048, 32'h0, rc, om, wl);
    n_checks++; if (rc !== 5 || Mem_out !== 32'hCCCC3333) begin n_fail++; $display("FAIL b2b_r1: got %0d/%h want 5/cccc3333", rc, Mem_out); end
    go_idle();
`ifdef SRAM_CTRL_COUNT_EN
    n_checks++; if (wr_count !== 16'd3) begin n_fail++; $display("FAIL wr_count: got %0d want 3", wr_count); end
    n_checks++; if (rd_count !== 16'd2) begin n_fail++; $display("FAIL rd_count: got %0d want 2", rd_count); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    test_reset();
    test_write();
    test_read();
    test_both();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
